// File: rtl/mem_loader_if.sv
// Load-side bus of mem_loader: input word stream, memory write port and status.
// MEM_LOADER_MAX_EN adds the max_value signal.
interface mem_loader_if #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  start;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [ADDR_WIDTH:0]   count;
    logic                  done;
`ifdef MEM_LOADER_MAX_EN
    logic [DATA_WIDTH-1:0] max_value;
`endif

    // master: the stream source / consumer of the write port
    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, done
`ifdef MEM_LOADER_MAX_EN
        , input max_value
`endif
    );

    // slave: the loader itself
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, count, done
`ifdef MEM_LOADER_MAX_EN
        , output max_value
`endif
    );
endinterface

// File: rtl/mem_loader.sv
// Writes DEPTH streamed words to addresses 0..DEPTH-1 and pulses done afterwards.
// Optional MEM_LOADER_MAX_EN tracks the running maximum of accepted words.
module mem_loader #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DEPTH      = 16
) (
    input logic         clk,
    input logic         rst,
    mem_loader_if.slave bus
);
    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StLoad, StFinish} state_e;

    state_e                state_q, state_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  done_q, done_d;
    logic                  accept;
    logic [CW-1:0]         count_inc;
`ifdef MEM_LOADER_MAX_EN
    logic [DATA_WIDTH-1:0] max_q, max_d;
`endif

    assign accept    = bus.in_valid && (state_q == StLoad);
    assign count_inc = count_q + CW'(1);

    always_comb begin
        state_d  = state_q;
        mem_we_d = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        count_d  = count_q;
        done_d   = 1'b0;
`ifdef MEM_LOADER_MAX_EN
        max_d    = max_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StLoad;
                    count_d = '0;
`ifdef MEM_LOADER_MAX_EN
                    max_d   = '0;
`endif
                end
            end
            StLoad: begin
                if (accept) begin
                    mem_we_d = 1'b1;
                    addr_d   = count_q[ADDR_WIDTH-1:0];
                    wdata_d  = bus.in_data;
                    count_d  = count_inc;
`ifdef MEM_LOADER_MAX_EN
                    if (bus.in_data > max_q) max_d = bus.in_data;
`endif
                    // Leaving LOAD here drops in_ready while the final write is on the bus.
                    if (count_inc == DepthCnt) state_d = StFinish;
                end
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            mem_we_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
`ifdef MEM_LOADER_MAX_EN
            max_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mem_we_q <= mem_we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            count_q  <= count_d;
            done_q   <= done_d;
`ifdef MEM_LOADER_MAX_EN
            max_q    <= max_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == StLoad);
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.count     = count_q;
    assign bus.done      = done_q;
`ifdef MEM_LOADER_MAX_EN
    assign bus.max_value = max_q;
`endif
endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: accepted words queue expected writes, checked on mem_we.
module tb_mem_loader;
    localparam int unsigned DW    = 6;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    wr_t exp_q[$];
    int exp_addr = 0;
    int wr_cnt = 0;
    int we_run = 0;
    int we_run_max = 0;
    bit prev_last = 1'b0;
    logic [DW-1:0] words [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: compare writes visible this cycle, then record the accept at the coming edge.
    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_cnt++;
            we_run++;
            if (we_run > we_run_max) we_run_max = we_run;
            if (exp_q.size() == 0) begin
                check("unexpected_we", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                check("wr_data", 32'(bus.mem_wdata), 32'(e.data));
            end
        end else begin
            we_run = 0;
        end
        if (bus.done) check("done_after_last", 32'(prev_last), 32'd1);
        prev_last = bus.mem_we && (bus.mem_addr == AW'(DEPTH - 1));
        if (rst && bus.in_valid && bus.in_ready) begin
            wr_t w;
            w.addr = exp_addr[AW-1:0];
            w.data = bus.in_data;
            exp_q.push_back(w);
            exp_addr++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: back-to-back valid, mode 1: valid toggling. abort_after>0 resets mid-load.
    task automatic load(input int mode, input bit pulse_start, input int abort_after);
        int idx = 0;
        int cyc = 0;
        bit acc;
        bit seen = 1'b0;
        logic [DW-1:0] mx = '0;
        exp_addr   = 0;
        wr_cnt     = 0;
        we_run_max = 0;
        bus.start    = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        bus.start = 1'b0;
        while (idx < DEPTH && cyc < 200) begin
            bus.in_valid = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
            bus.in_data  = words[idx];
            bus.start    = pulse_start && (idx == 7);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) idx++;
            cyc++;
            if (abort_after != 0 && idx == abort_after) break;
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        if (abort_after != 0) begin
            check("abort_accepts", 32'(idx), 32'(abort_after));
            rst          = 1'b0;
            bus.in_valid = 1'b1;
            tick();
            @(negedge clk);
            check("rst_we", 32'(bus.mem_we), 32'd0);
            check("rst_count", 32'(bus.count), 32'd0);
            check("rst_ready", 32'(bus.in_ready), 32'd0);
            check("rst_queue", 32'(exp_q.size()), 32'd0);
            rst          = 1'b1;
            bus.in_valid = 1'b0;
            tick();
            return;
        end
        check("load_accepts", 32'(idx), 32'(DEPTH));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("done_count", 32'(bus.count), 32'(DEPTH));
        check("done_addr", 32'(bus.mem_addr), 32'(DEPTH - 1));
        check("wr_total", 32'(wr_cnt), 32'(DEPTH));
        check("we_run", 32'(we_run_max), (mode == 0) ? 32'(DEPTH) : 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef MEM_LOADER_MAX_EN
        for (int i = 0; i < DEPTH; i++) if (words[i] > mx) mx = words[i];
        check("max_value", 32'(bus.max_value), 32'(mx));
`endif
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        // 1: reset with random inputs
        for (int i = 0; i < 2; i++) begin
            bus.start    = 1'($urandom);
            bus.in_valid = 1'($urandom);
            bus.in_data  = DW'($urandom);
            tick();
        end
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_cnt", 32'(bus.count), 32'd0);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        tick();

        // 2: back-to-back load of 0..15
        for (int i = 0; i < DEPTH; i++) words[i] = DW'(i);
        load(0, 1'b0, 0);
        // 3: bubbles on in_valid
        load(1, 1'b0, 0);

        // 4: valid in IDLE without start; count holds from last load
        bus.in_valid = 1'b1;
        bus.in_data  = 6'h2A;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(bus.in_ready), 32'd0);
            check("idle_we", 32'(bus.mem_we), 32'd0);
            check("idle_count", 32'(bus.count), 32'(DEPTH));
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        load(0, 1'b1, 0);

        // 5: reset after the 5th accept, then a clean load from address 0
        for (int i = 0; i < DEPTH; i++) words[i] = DW'(DEPTH - 1 - i);
        load(0, 1'b0, 5);
        load(0, 1'b0, 0);

        // 6: running maximum
        words[0] = 6'h12;
        words[1] = 6'h3F;
        words[2] = 6'h07;
        for (int i = 3; i < DEPTH; i++) words[i] = DW'((i * 5) % 63);
        load(1, 1'b0, 0);
        for (int i = 0; i < DEPTH; i++) words[i] = 6'h05;
        load(0, 1'b0, 0);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
